// File: rtl/mul_div_unit.sv
// Iterative multi-cycle MUL / DIVU / REMU unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one step per cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o
);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               zero_q, zero_d;

    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   res;

    // Shifted remainder and trial subtraction share WIDTH+1 bits
    assign rem_sh   = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, b_q};
    assign q_bit    = ~rem_diff[WIDTH];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        data_d  = data_q;
        zero_d  = zero_q;
        res     = '0;
        unique case (state_q)
            IDLE: begin
                if (start_i && op_i != OP_RSV) begin
                    op_d  = op_i;
                    a_d   = {{WIDTH{1'b0}}, data1_i};
                    b_d   = data2_i;
                    acc_d = '0;
                    cnt_d = '0;
                    if (op_i != OP_MUL && data2_i == '0) begin
                        res     = (op_i == OP_DIVU) ? '1 : data1_i;
                        data_d  = res;
                        zero_d  = (res == '0);
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q == OP_MUL) begin
                    if (b_q[0]) begin
                        acc_d = acc_q + a_q;
                    end
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                    res = acc_d[WIDTH-1:0];
                end else begin
                    a_d = {a_q[2*WIDTH-1:WIDTH], a_q[WIDTH-2:0], q_bit};
                    if (q_bit) begin
                        acc_d = {{WIDTH{1'b0}}, rem_diff[WIDTH-1:0]};
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, rem_sh[WIDTH-1:0]};
                    end
                    res = (op_q == OP_REMU) ? acc_d[WIDTH-1:0]
                                            : a_d[WIDTH-1:0];
                end
                if (cnt_q == LAST) begin
                    data_d  = res;
                    zero_d  = (res == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
        end
    end

    assign busy_o = (state_q == CALC);
    assign done_o = (state_q == DONE);
    assign data_o = data_q;
    assign Zero_o = zero_q;

endmodule
